// File: rtl/sgpr_load_writeback_if.sv
// Bundles the request, memory-return and SGPR destination signals of the
// SGPR load writeback unit. The slave modport is the writeback unit itself.
interface sgpr_load_writeback_if #(
  parameter int ADDR_W = 9,
  parameter int WFID_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        req_dwords;
  logic [WFID_W-1:0] req_wfid;

  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [31:0]       mem_rsp_data;

  logic [ADDR_W-1:0] lsu_dest_addr;
  logic [127:0]      lsu_dest_data;
  logic [3:0]        lsu_dest_wr_en;
  logic              lsu_instr_done;
  logic [WFID_W-1:0] lsu_instr_done_wfid;

  modport master (
    output req_valid, req_addr, req_dwords, req_wfid,
    output mem_rsp_valid, mem_rsp_data,
    input  req_ready, mem_rsp_ready,
    input  lsu_dest_addr, lsu_dest_data, lsu_dest_wr_en,
    input  lsu_instr_done, lsu_instr_done_wfid
  );

  modport slave (
    input  req_valid, req_addr, req_dwords, req_wfid,
    input  mem_rsp_valid, mem_rsp_data,
    output req_ready, mem_rsp_ready,
    output lsu_dest_addr, lsu_dest_data, lsu_dest_wr_en,
    output lsu_instr_done, lsu_instr_done_wfid
  );
endinterface

// File: rtl/sgpr_load_writeback.sv
// Return-side SGPR writer: collects scalar-load return dwords, writes them to
// the SGPR file in groups of up to four lanes, then signals completion.
module sgpr_load_writeback #(
  parameter int MAX_DWORDS = 16,
  parameter int ADDR_W     = 9,
  parameter int WFID_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  sgpr_load_writeback_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] base_addr;
  logic [WFID_W-1:0] wfid_q;
  logic [4:0]        count;
  logic [4:0]        consumed;
  logic [2:0]        idx;
  logic [2:0]        group;
  logic [3:0][31:0]  lanes;

  logic [ADDR_W-1:0] dest_addr;
  logic [127:0]      dest_data;
  logic [3:0]        dest_wr_en;
  logic              instr_done;
  logic [WFID_W-1:0] done_wfid;

  logic       accept;
  logic       beat_fire;
  logic       group_last;
  logic       more_left;
  logic [4:0] req_count;
  logic [3:0] wr_mask;

  // Ready is held low during reset so every output reads 0 while rst is asserted.
  assign bus.req_ready     = rst && !flush && (state == IDLE);
  assign bus.mem_rsp_ready = (state == COLLECT);

  assign accept    = bus.req_valid && bus.req_ready;
  assign beat_fire = (state == COLLECT) && bus.mem_rsp_valid;
  assign more_left = (consumed != count);
  assign req_count = (bus.req_dwords > 5'(MAX_DWORDS)) ? 5'(MAX_DWORDS) : bus.req_dwords;

  assign bus.lsu_dest_addr       = dest_addr;
  assign bus.lsu_dest_data       = dest_data;
  assign bus.lsu_dest_wr_en      = dest_wr_en;
  assign bus.lsu_instr_done      = instr_done;
  assign bus.lsu_instr_done_wfid = done_wfid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    group_last = 1'b0;
    wr_mask    = 4'b0000;

    case (idx)
      3'd1:    wr_mask = 4'b0001;
      3'd2:    wr_mask = 4'b0011;
      3'd3:    wr_mask = 4'b0111;
      3'd4:    wr_mask = 4'b1111;
      default: wr_mask = 4'b0000;
    endcase

    // A group closes when lane 3 fills or the request runs out of dwords.
    if (beat_fire && ((idx == 3'd3) || (consumed + 5'd1 == count)))
      group_last = 1'b1;

    case (state)
      IDLE: begin
        if (accept) state_next = (req_count == 5'd0) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (group_last) state_next = WRITE;
      end
      WRITE: begin
        state_next = more_left ? COLLECT : DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_addr  <= '0;
      wfid_q     <= '0;
      count      <= '0;
      consumed   <= '0;
      idx        <= '0;
      group      <= '0;
      lanes      <= '0;
      dest_addr  <= '0;
      dest_data  <= '0;
      dest_wr_en <= '0;
      instr_done <= 1'b0;
      done_wfid  <= '0;
    end else begin
      dest_wr_en <= '0;
      instr_done <= 1'b0;

      if (flush) begin
        consumed <= '0;
        idx      <= '0;
        group    <= '0;
        lanes    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              base_addr <= bus.req_addr;
              wfid_q    <= bus.req_wfid;
              count     <= req_count;
              consumed  <= '0;
              idx       <= '0;
              group     <= '0;
              lanes     <= '0;
            end
          end
          COLLECT: begin
            if (beat_fire) begin
              lanes[idx[1:0]] <= bus.mem_rsp_data;
              idx             <= idx + 3'd1;
              consumed        <= consumed + 5'd1;
            end
          end
          WRITE: begin
            // Lanes are cleared after each write, so unfilled lanes go out as zero.
            dest_addr  <= base_addr + ADDR_W'({group, 2'b00});
            dest_data  <= lanes;
            dest_wr_en <= wr_mask;
            lanes      <= '0;
            idx        <= '0;
            if (more_left) group <= group + 3'd1;
          end
          DONE: begin
            instr_done <= 1'b1;
            done_wfid  <= wfid_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sgpr_load_writeback.sv
// Directed self-checking bench for sgpr_load_writeback: drives requests and
// return beats, logs every SGPR write and done pulse, and checks them.
module tb_sgpr_load_writeback;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  sgpr_load_writeback_if #(.ADDR_W(9), .WFID_W(6)) bus ();

  sgpr_load_writeback #(
    .MAX_DWORDS(16),
    .ADDR_W(9),
    .WFID_W(6)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acceptCycle = 0;

  logic [31:0]  beatMem [0:15];
  logic [8:0]   wAddr  [$];
  logic [3:0]   wEn    [$];
  logic [127:0] wData  [$];
  int           wCycle [$];
  logic [5:0]   dWfid  [$];
  int           dCycle [$];

  // Cycle counter advances on the active edge; the log samples on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.lsu_dest_wr_en != 4'b0000) begin
      wAddr.push_back(bus.lsu_dest_addr);
      wEn.push_back(bus.lsu_dest_wr_en);
      wData.push_back(bus.lsu_dest_data);
      wCycle.push_back(cyc);
    end
    if (bus.lsu_instr_done) begin
      dWfid.push_back(bus.lsu_instr_done_wfid);
      dCycle.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    wAddr.delete();
    wEn.delete();
    wData.delete();
    wCycle.delete();
    dWfid.delete();
    dCycle.delete();
  endtask

  // Issues one request and then nBeats return dwords from beatMem; gapMod>0 inserts
  // (i % gapMod) idle cycles before beat i.
  task automatic applyStimulus(input logic [8:0] addr, input logic [4:0] dwords,
                               input logic [5:0] wfid, input int nBeats, input int gapMod);
    int waitCnt;
    int gap;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_dwords = dwords;
    bus.req_wfid   = wfid;
    waitCnt = 0;
    while (!bus.req_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("req_accept", bus.req_ready, 1);
    acceptCycle = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      gap = (gapMod > 0) ? (i % gapMod) : 0;
      bus.mem_rsp_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = beatMem[i];
      waitCnt = 0;
      while (!bus.mem_rsp_ready && waitCnt < 50) begin
        @(negedge clk);
        waitCnt++;
      end
      if (!bus.mem_rsp_ready) checkOutput("beat_ready_timeout", bus.mem_rsp_ready, 1);
      @(negedge clk);
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'h0;
  endtask

  task automatic waitForDone(input int n);
    int budget = 0;
    while (dWfid.size() < n && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("done_seen", (dWfid.size() >= n), 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_addr      = '0;
    bus.req_dwords    = '0;
    bus.req_wfid      = '0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_wr_en",     bus.lsu_dest_wr_en, 0);
    checkOutput("rst_addr",      bus.lsu_dest_addr, 0);
    checkOutput("rst_data",      bus.lsu_dest_data, 0);
    checkOutput("rst_done",      bus.lsu_instr_done, 0);
    checkOutput("rst_wfid",      bus.lsu_instr_done_wfid, 0);
    checkOutput("rst_req_ready", bus.req_ready, 0);
    checkOutput("rst_rsp_ready", bus.mem_rsp_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_req_ready", bus.req_ready, 1);

    // 1: single dword
    clearLog();
    beatMem[0] = 32'hf0f0f0f0;
    applyStimulus(9'd50, 5'd1, 6'd3, 1, 0);
    waitForDone(1);
    checkOutput("t1_nwrites", wAddr.size(), 1);
    if (wAddr.size() == 1) begin
      checkOutput("t1_addr", wAddr[0], 9'd50);
      checkOutput("t1_en",   wEn[0], 4'b0001);
      checkOutput("t1_data", wData[0], 128'h0000_0000_0000_0000_0000_0000_f0f0_f0f0);
    end
    checkOutput("t1_ndone", dWfid.size(), 1);
    if (dWfid.size() == 1) checkOutput("t1_wfid", dWfid[0], 6'd3);

    // 2: four dwords back to back, latency
    clearLog();
    beatMem[0] = 32'h0000a0a0;
    beatMem[1] = 32'h0000dead;
    beatMem[2] = 32'h0000babe;
    beatMem[3] = 32'h00001234;
    applyStimulus(9'd100, 5'd4, 6'd12, 4, 0);
    waitForDone(1);
    checkOutput("t2_nwrites", wAddr.size(), 1);
    if (wAddr.size() == 1) begin
      checkOutput("t2_addr", wAddr[0], 9'd100);
      checkOutput("t2_en",   wEn[0], 4'b1111);
      checkOutput("t2_data", wData[0], 128'h0000_1234_0000_babe_0000_dead_0000_a0a0);
      checkOutput("t2_wr_latency", wCycle[0] - acceptCycle, 6);
    end
    checkOutput("t2_ndone", dWfid.size(), 1);
    if (dWfid.size() == 1) begin
      checkOutput("t2_wfid", dWfid[0], 6'd12);
      checkOutput("t2_done_latency", dCycle[0] - acceptCycle, 7);
    end

    // 3: sixteen dwords with valid gaps
    clearLog();
    for (int i = 0; i < 16; i++) beatMem[i] = 32'hc0de_0000 + 32'(i);
    applyStimulus(9'd96, 5'd16, 6'd21, 16, 3);
    waitForDone(1);
    checkOutput("t3_nwrites", wAddr.size(), 4);
    if (wAddr.size() == 4) begin
      for (int g = 0; g < 4; g++) begin
        checkOutput($sformatf("t3_addr%0d", g), wAddr[g], 9'(96 + 4 * g));
        checkOutput($sformatf("t3_en%0d", g), wEn[g], 4'b1111);
        checkOutput($sformatf("t3_data%0d", g), wData[g],
                    {beatMem[4*g+3], beatMem[4*g+2], beatMem[4*g+1], beatMem[4*g]});
      end
      if (dCycle.size() == 1) checkOutput("t3_done_after_last", dCycle[0] > wCycle[3], 1);
    end
    checkOutput("t3_ndone", dWfid.size(), 1);

    // 4: address wrap
    clearLog();
    for (int i = 0; i < 6; i++) beatMem[i] = 32'h5a00_0000 + 32'(i);
    applyStimulus(9'd510, 5'd6, 6'd33, 6, 0);
    waitForDone(1);
    checkOutput("t4_nwrites", wAddr.size(), 2);
    if (wAddr.size() == 2) begin
      checkOutput("t4_addr0", wAddr[0], 9'd510);
      checkOutput("t4_en0",   wEn[0], 4'b1111);
      checkOutput("t4_data0", wData[0], 128'h5a00_0003_5a00_0002_5a00_0001_5a00_0000);
      checkOutput("t4_addr1", wAddr[1], 9'd2);
      checkOutput("t4_en1",   wEn[1], 4'b0011);
      checkOutput("t4_data1", wData[1], 128'h0000_0000_0000_0000_5a00_0005_5a00_0004);
    end

    // 5: zero dwords
    clearLog();
    applyStimulus(9'd7, 5'd0, 6'd9, 0, 0);
    waitForDone(1);
    checkOutput("t5_nwrites", wAddr.size(), 0);
    checkOutput("t5_ndone", dWfid.size(), 1);
    if (dWfid.size() == 1) begin
      checkOutput("t5_wfid", dWfid[0], 6'd9);
      checkOutput("t5_done_latency", dCycle[0] - acceptCycle, 2);
    end

    // 6a: flush after 2 of 8 beats, then a fresh request
    clearLog();
    beatMem[0] = 32'h1111_1111;
    beatMem[1] = 32'h2222_2222;
    applyStimulus(9'd200, 5'd8, 6'd5, 2, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("t6_flush_nwrites", wAddr.size(), 0);
    checkOutput("t6_flush_ndone", dWfid.size(), 0);
    beatMem[0] = 32'h3333_3333;
    beatMem[1] = 32'h4444_4444;
    applyStimulus(9'd20, 5'd2, 6'd7, 2, 0);
    waitForDone(1);
    checkOutput("t6_nwrites", wAddr.size(), 1);
    if (wAddr.size() == 1) begin
      checkOutput("t6_addr", wAddr[0], 9'd20);
      checkOutput("t6_en",   wEn[0], 4'b0011);
      checkOutput("t6_data", wData[0], 128'h0000_0000_0000_0000_4444_4444_3333_3333);
    end
    if (dWfid.size() == 1) checkOutput("t6_wfid", dWfid[0], 6'd7);

    // 6b: flush with req_valid in IDLE drops the request
    clearLog();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 9'd40;
    bus.req_dwords = 5'd0;
    bus.req_wfid   = 6'd44;
    flush = 1'b1;
    #1;
    checkOutput("t6_flush_idle_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    flush = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t6_flush_idle_ndone", dWfid.size(), 0);

    // 6c: reset mid-request
    clearLog();
    beatMem[0] = 32'h5555_5555;
    applyStimulus(9'd300, 5'd4, 6'd11, 1, 0);
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_req_ready", bus.req_ready, 0);
    checkOutput("t6_rst_rsp_ready", bus.mem_rsp_ready, 0);
    checkOutput("t6_rst_data", bus.lsu_dest_data, 0);
    checkOutput("t6_rst_addr", bus.lsu_dest_addr, 0);
    checkOutput("t6_rst_wfid", bus.lsu_instr_done_wfid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t6_rst_nwrites", wAddr.size(), 0);
    checkOutput("t6_rst_ndone", dWfid.size(), 0);
    beatMem[0] = 32'h6666_6666;
    applyStimulus(9'd8, 5'd1, 6'd13, 1, 0);
    waitForDone(1);
    checkOutput("t6_after_rst_nwrites", wAddr.size(), 1);
    if (wAddr.size() == 1) checkOutput("t6_after_rst_data", wData[0], 128'h6666_6666);
    if (dWfid.size() == 1) checkOutput("t6_after_rst_wfid", dWfid[0], 6'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
